// File: rtl/regfile_sweep.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass, per-register dirty bits and a one-register-per-cycle clear sweep.

module regfile_sweep_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              dirty
);
  // clr and wr are mutually exclusive: writes are only accepted while idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q     <= '0;
      dirty <= 1'b0;
    end else if (clr) begin
      q     <= '0;
      dirty <= 1'b0;
    end else if (wr) begin
      q     <= d;
      dirty <= 1'b1;
    end
  end
endmodule

module regfile_sweep #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [ADDR_W-1:0]    rs_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [DATA_W-1:0]    rs_data,
  input  logic [ADDR_W-1:0]    w_addr,
  input  logic [DATA_W-1:0]    w_data,
  input  logic                 w_en,
  output logic                 w_drop,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  output logic [2**ADDR_W-1:0] dirty
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_W-1:0]              ptr, ptr_nxt;
  logic                           clr_done_nxt;
  logic                           accept;
  logic [NREG-1:0][DATA_W-1:0]    regs;

  assign busy   = (state == CLEAR);
  assign w_drop = w_en & busy;
  assign accept = w_en & ~busy & ~((ZERO_R0 != 0) && (w_addr == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(NREG-1)) begin
          state_nxt    = IDLE;
          clr_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    regfile_sweep_cell #(.DATA_W(DATA_W)) u_cell (
      .clock (clock),
      .reset (reset),
      .wr    (accept && (w_addr == ADDR_W'(i))),
      .clr   (busy && (ptr == ADDR_W'(i))),
      .d     (w_data),
      .q     (regs[i]),
      .dirty (dirty[i])
    );
  end

  // accept already excludes r0 under ZERO_R0, so the zero override cannot be bypassed around
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0]             a,
    input logic [NREG-1:0][DATA_W-1:0]   r,
    input logic                          acc,
    input logic [ADDR_W-1:0]             wa,
    input logic [DATA_W-1:0]             wd
  );
    logic [DATA_W-1:0] v;
    v = r[a];
    if ((BYPASS != 0) && acc && (wa == a)) v = wd;
    if ((ZERO_R0 != 0) && (a == '0))       v = '0;
    return v;
  endfunction

  always_comb begin
    rd_data = rd_port(rd_addr, regs, accept, w_addr, w_data);
    rs_data = rd_port(rs_addr, regs, accept, w_addr, w_data);
  end
endmodule
